// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply, restoring divide, single-cycle MTHI/MTLO.
module muldiv_unit #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WORD_SIZE-1:0] s_data,
  input  logic [WORD_SIZE-1:0] t_data,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]  cnt;
  logic           neg_q;
  logic           rneg_q;
  logic           div_q;
  logic           dz_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   s_raw;
  logic [W-1:0]   quo;
  logic [W:0]     rem;
  logic [2*W-1:0] acc;

  logic         is_mul;
  logic         is_div;
  logic         is_mthi;
  logic         is_mtlo;
  logic         sgn_op;
  logic         idle;
  logic [W-1:0] s_mag;
  logic [W-1:0] t_mag;

  logic [W:0]     mul_sum;
  logic [W+1:0]   div_sh;
  logic [W+1:0]   div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  assign idle = (state == IDLE);
  assign busy = ~idle;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    sgn_op  = 1'b0;
    case (op)
      OP_MULT: begin
        is_mul = 1'b1;
        sgn_op = 1'b1;
      end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV: begin
        is_div = 1'b1;
        sgn_op = 1'b1;
      end
      OP_DIVU: is_div  = 1'b1;
      OP_MTHI: is_mthi = 1'b1;
      OP_MTLO: is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign s_mag = (sgn_op && s_data[W-1]) ? -s_data : s_data;
  assign t_mag = (sgn_op && t_data[W-1]) ? -t_data : t_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start && is_mul) begin
          state_nx = MUL;
        end else if (start && is_div) begin
          state_nx = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt == '0) begin
          state_nx = FIX;
        end
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift-add: add multiplicand into the upper half when the low bit is set.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, b_q};

  // Restoring step; a borrow in the top bit means the trial subtract fails.
  assign div_sh   = {rem, quo[W-1]};
  assign div_diff = div_sh - {2'b00, b_q};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = rneg_q ? -rem[W-1:0] : rem[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div_q  <= 1'b0;
      dz_q   <= 1'b0;
      b_q    <= '0;
      s_raw  <= '0;
      quo    <= '0;
      rem    <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (is_mul || is_div)) begin
            neg_q  <= sgn_op & (s_data[W-1] ^ t_data[W-1]);
            rneg_q <= sgn_op & s_data[W-1];
            div_q  <= is_div;
            dz_q   <= (t_data == '0);
            s_raw  <= s_data;
            b_q    <= is_mul ? s_mag : t_mag;
            acc    <= {{W{1'b0}}, t_mag};
            quo    <= s_mag;
            rem    <= '0;
            cnt    <= CW'(W - 1);
          end
          if (start && is_mthi) begin
            hi <= s_data;
          end
          if (start && is_mtlo) begin
            lo <= s_data;
          end
        end
        MUL: begin
          if (acc[0]) begin
            acc <= {mul_sum, acc[W-1:1]};
          end else begin
            acc <= {1'b0, acc[2*W-1:1]};
          end
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (div_diff[W+1]) begin
            rem <= div_sh[W:0];
            quo <= {quo[W-2:0], 1'b0};
          end else begin
            rem <= div_diff[W:0];
            quo <= {quo[W-2:0], 1'b1};
          end
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!div_q) begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end else if (dz_q) begin
            hi <= s_raw;
            lo <= {W{1'b1}};
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed MUL/DIV/MTHI/MTLO
// vectors, busy-length, hold, start-while-busy and reset abort.
module tb_muldiv_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] h;
    logic [W-1:0] l;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] s_data;
  logic [W-1:0] t_data;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  exp_t sbq[$];
  exp_t mtq[$];

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  muldiv_unit #(.WORD_SIZE(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .s_data (s_data),
    .t_data (t_data),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares on busy falling and one cycle after MT accepts.
  logic         prev_busy = 1'b0;
  logic         chg = 1'b0;
  int           bcnt = 0;
  logic [W-1:0] h0;
  logic [W-1:0] l0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
      bcnt      = 0;
      chg       = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          h0   = hi;
          l0   = lo;
          chg  = 1'b0;
          bcnt = 0;
        end
        bcnt++;
        if (hi !== h0 || lo !== l0) chg = 1'b1;
      end else if (prev_busy) begin
        chk("busy_len", 64'(bcnt), 64'(W + 1));
        chk("hold_during_busy", {63'd0, chg}, 64'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_result", {hi, lo}, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("result_hilo", {hi, lo}, {e.h, e.l});
        end
      end
      if (mtq.size() > 0) begin
        e = mtq.pop_front();
        chk("mt_hilo", {hi, lo}, {e.h, e.l});
        chk("mt_busy", {63'd0, busy}, 64'd0);
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] s,
                       input logic [W-1:0] t, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input bit push);
    exp_t e;
    start  = 1'b1;
    op     = o;
    s_data = s;
    t_data = t;
    @(posedge clk);
    if (push) begin
      e.h = eh;
      e.l = el;
      if (o <= 3'd3) sbq.push_back(e);
      else mtq.push_back(e);
    end
    #1;
    start  = 1'b0;
    s_data = $urandom;
    t_data = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n >= 60) chk("busy_timeout", 64'(n), 64'd0);
  endtask

  task automatic muldiv(input logic [2:0] o, input logic [W-1:0] s,
                        input logic [W-1:0] t, input logic [W-1:0] eh,
                        input logic [W-1:0] el);
    issue(o, s, t, eh, el, 1'b1);
    m_hi = eh;
    m_lo = el;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    s_data = '0;
    t_data = '0;
    m_hi   = '0;
    m_lo   = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    muldiv(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    muldiv(3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    muldiv(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    muldiv(3'd0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6);
    muldiv(3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    muldiv(3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    muldiv(3'd3, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF);
    muldiv(3'd2, 32'hFFFFFFF6, 32'h00000000, 32'hFFFFFFF6, 32'hFFFFFFFF);

    // DIVU with an MTLO pulse while busy that must be ignored
    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    m_hi = 32'd2;
    m_lo = 32'd14;
    repeat (5) @(negedge clk);
    start  = 1'b1;
    op     = 3'd5;
    s_data = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // MTHI then MTLO on consecutive cycles, then a no-op
    issue(3'd4, 32'h12345678, 32'h0, 32'h12345678, m_lo, 1'b1);
    m_hi = 32'h12345678;
    issue(3'd5, 32'h9ABCDEF0, 32'h0, m_hi, 32'h9ABCDEF0, 1'b1);
    m_lo = 32'h9ABCDEF0;
    issue(3'd6, 32'h55555555, 32'h0, m_hi, m_lo, 1'b1);
    @(negedge clk);

    // Reset mid-multiply: nothing may be written afterwards
    issue(3'd1, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_late_write", {hi, lo}, 64'd0);
    chk("idle_after_rst", {63'd0, busy}, 64'd0);

    muldiv(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    muldiv(3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    chk("mt_drained", 64'(mtq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits directly downstream of the register file and takes the rs/rt read data (`s_data`/`t_data`) as operands. It runs MULT/MULTU/DIV/DIVU over multiple cycles and handles MTHI/MTLO in a single cycle. It exposes `hi`/`lo` for MFHI/MFLO and a `busy` flag that pipeline control uses to stall.

## Interface
- `WORD_SIZE`, 32: operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy` is 0.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `s_data`  in  WORD_SIZE  rs operand (dividend/multiplicand; MTHI/MTLO source).
- `t_data`  in  WORD_SIZE  rt operand (divisor/multiplier).
- `busy`  out  1  high while a multiply/divide is in flight.
- `hi`  out  WORD_SIZE  HI register.
- `lo`  out  WORD_SIZE  LO register.

## Operation
- **Reset:** `rst_n` low asynchronously forces:
  - state to IDLE, iteration counter to 0, all internal datapath registers to 0;
  - `hi` = 0, `lo` = 0, `busy` = 0.
- **Reset mid-operation:** the in-flight result is discarded; nothing is written to HI/LO afterwards.
- **States:** IDLE, MUL, DIV, FIX. `busy` = (state != IDLE), decoded directly from the state register.
- **IDLE:**
  - `start` with op 0/1 → MUL.
  - `start` with op 2/3 → DIV.
  - `start` with op 4 → `hi` <= `s_data` this edge; stays IDLE.
  - `start` with op 5 → `lo` <= `s_data` this edge; stays IDLE.
  - `start` with op 6/7 → no effect.
- **On accepting a multiply/divide:**
  - Latch operand magnitudes: `|x|` for signed ops, raw value for unsigned ops.
  - Latch result sign flags and the op.
  - Load counter = WORD_SIZE−1.
- **MUL:** one shift-add iteration per cycle on a 2·WORD_SIZE-bit accumulator. The counter decrements each cycle; the state moves to FIX after the iteration at counter 0.
- **DIV:** one restoring shift-subtract iteration per cycle (partial remainder WORD_SIZE+1 bits). Exit to FIX is the same as MUL.
- **FIX:** apply sign correction, write `hi`/`lo`, go to IDLE.
- **Arithmetic rules:**
  - Multiply: {hi,lo} = 2·WORD_SIZE-bit product. For MULT, the product is negated when the operand signs differ.
  - Divide: lo = quotient, hi = remainder.
  - DIV quotient is negated when the operand signs differ; DIV remainder takes the sign of the dividend (truncating division).
  - DIV of most-negative by −1 → lo = most-negative, hi = 0. This needs no special case.
  - Divide by zero (DIV or DIVU) → lo = all ones, hi = `s_data` as latched. This is forced in FIX regardless of sign.
- **HI/LO visibility:** `hi`/`lo` keep their previous values for the whole operation and change only at the FIX edge.
- **start while busy:** ignored entirely, with no operand latch and no HI/LO write. This includes MTHI/MTLO; control must stall them.
- **Operands:** sampled only on the accept edge and may change freely afterwards.

## Timing
- Accept edge = the rising edge where `start` is high and `busy` is 0.
- **Multiply/divide:**
  - `busy` rises in the cycle after the accept edge.
  - Iterations occur on accept+1 … accept+WORD_SIZE.
  - FIX occurs on edge accept+WORD_SIZE+1; at that edge `hi`/`lo` update and `busy` falls together.
  - `busy` is high for exactly WORD_SIZE+1 cycles (33 at default).
- **Back-to-back:** a new `start` is accepted in the first cycle `busy` is 0. Its operands may come from a regfile read of the just-written HI/LO via MFHI/MFLO.
- **MTHI/MTLO:** the new value appears on `hi`/`lo` the cycle after the accept edge; `busy` stays 0.
- **Outputs:** `hi`, `lo` and `busy` are registered or decoded from registers only. There is no combinational path from any input.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 10 / 0 → lo=0xFFFFFFFF, hi=0x0000000A; DIVU 100 / 7 → lo=14, hi=2.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → `hi`/`lo` take the values one cycle after each accept, `busy` stays 0. Start DIVU, pulse MTLO mid-busy → ignored, and the final lo is the quotient.
- Start MULTU, assert `rst_n`=0 at cycle 10 → `busy`/`hi`/`lo` go to 0 immediately. After release, no late write occurs, and a fresh op completes correctly.
